// File: rtl/test_monitor_pkg.sv
// Shared definitions for the riscv-tests completion monitor.
package test_monitor_pkg;

    // Monitor FSM states
    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        RUN     = 3'd1,
        PASS    = 3'd2,
        FAIL    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    // tohost value signalling a passing test
    localparam int unsigned TOHOST_PASS = 1;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Clear wins; otherwise count up and stick at all-ones
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/test_monitor.sv
// Holds the Core in reset, then watches stores to tohost and reports
// pass/fail/timeout. Optional instret counter via TEST_MONITOR_INSTRET_EN.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int unsigned       XLEN           = 32,
    parameter int unsigned       CNT_W          = 32,
    parameter logic [XLEN-1:0]   TOHOST_ADDR    = XLEN'(32'h0000_1000),
    parameter int unsigned       RESET_CYCLES   = 2,
    parameter int unsigned       TIMEOUT_CYCLES = 5000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             core_rst,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    input  logic             instret,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_id,
    output logic [CNT_W-1:0] cycle_count
`ifdef TEST_MONITOR_INSTRET_EN
    ,
    output logic [CNT_W-1:0] instret_count
`endif
);

    localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hit;
    logic              pass_hit;
    logic              fail_hit;
    logic              last_cycle;
    logic              cnt_clear;
    logic              in_run;

    // Decode the tohost store and the final RUN cycle
    always_comb begin
        hit        = mem_we && (mem_addr == TOHOST_ADDR);
        pass_hit   = hit && (mem_wdata == XLEN'(TOHOST_PASS));
        fail_hit   = hit && mem_wdata[0] && (mem_wdata != XLEN'(TOHOST_PASS));
        last_cycle = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_clear  = rst || (state == HOLD);
        in_run     = (state == RUN);
    end

    // Monitor FSM with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOLD;
            hold_cnt <= '0;
            core_rst <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            timeout  <= 1'b0;
            fail_id  <= '0;
        end else begin
            case (state)
                HOLD: begin
                    core_rst <= 1'b1;
                    if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                        core_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // A decisive tohost write takes priority over timeout
                    if (pass_hit) begin
                        state    <= PASS;
                        pass     <= 1'b1;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                    end else if (fail_hit) begin
                        state    <= FAIL;
                        fail     <= 1'b1;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                        fail_id  <= mem_wdata[XLEN-1:1];
                    end else if (last_cycle) begin
                        state    <= TIMEOUT;
                        timeout  <= 1'b1;
                        done     <= 1'b1;
                        core_rst <= 1'b1;
                    end
                end
                PASS, FAIL, TIMEOUT: begin
                    // Terminal: hold status and keep the Core frozen
                    core_rst <= 1'b1;
                end
                default: begin
                    state    <= HOLD;
                    hold_cnt <= '0;
                    core_rst <= 1'b1;
                end
            endcase
        end
    end

    // RUN-cycle counter, restarted from zero on every HOLD
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .clear  (cnt_clear),
        .enable (in_run),
        .count  (cycle_count)
    );

`ifdef TEST_MONITOR_INSTRET_EN
    // Retired-instruction counter, only live while the Core runs
    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk    (clk),
        .clear  (cnt_clear),
        .enable (in_run && instret),
        .count  (instret_count)
    );
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TOHOST_ADDR, 32'h0000_1000, byte address of the riscv-tests tohost word.
- RESET_CYCLES, 2, cycles core_rst is held after rst deasserts (>=1).
- TIMEOUT_CYCLES, 5000, RUN cycles before timeout (>=2).
- XLEN, 32, address/data width.
- CNT_W, 32, cycle/instret counter width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, synchronous active-high reset.
- core_rst, out, 1, reset driven to Core.
- mem_we, in, 1, Core data-store strobe.
- mem_addr, in, XLEN, store address.
- mem_wdata, in, XLEN, store data.
- instret, in, 1, one-cycle pulse per retired instruction.
- done, out, 1, test finished (any outcome).
- pass, out, 1, tohost==1 seen.
- fail, out, 1, odd tohost!=1 seen.
- timeout, out, 1, TIMEOUT_CYCLES elapsed.
- fail_id, out, XLEN-1, failing test number (tohost>>1).
- cycle_count, out, CNT_W, RUN cycles elapsed.

Function
REQ-003 FSM states HOLD, RUN, PASS, FAIL, TIMEOUT; rst forces HOLD.
REQ-004 HOLD: core_rst=1; hold counter counts RESET_CYCLES cycles, then RUN; stores ignored.
REQ-005 RUN: core_rst=0; cycle_count increments by 1 each cycle, starting at 0 on RUN entry.
REQ-006 Tohost hit = mem_we && mem_addr==TOHOST_ADDR, sampled at posedge in RUN only.
REQ-007 Hit with mem_wdata==1 -> PASS next cycle.
REQ-008 Hit with mem_wdata[0]==1 and mem_wdata!=1 -> FAIL next cycle; fail_id latched = mem_wdata[XLEN-1:1].
REQ-009 Hit with mem_wdata[0]==0 -> ignored, stay RUN.
REQ-010 cycle_count==TIMEOUT_CYCLES-1 in RUN without hit -> TIMEOUT next cycle.
REQ-011 Hit and timeout in same cycle: hit wins (PASS/FAIL).
REQ-012 PASS/FAIL/TIMEOUT terminal and sticky until rst; core_rst=1 in terminal states (freezes Core); cycle_count frozen.
REQ-013 done = PASS|FAIL|TIMEOUT; pass/fail/timeout one-hot decode of state, registered, mutually exclusive.
REQ-014 Outputs are registered; status visible the cycle after the causing edge.
REQ-015 cycle_count saturates at all-ones, no wrap.

Reset
REQ-016 On rst: state HOLD, core_rst=1, done/pass/fail/timeout=0, fail_id=0, cycle_count=0, hold counter=0.
REQ-017 rst mid-RUN or in terminal state restarts the full HOLD sequence; no status survives.

Configuration
REQ-018 Macro TEST_MONITOR_INSTRET_EN: when defined, adds output instret_count (CNT_W), cleared on rst, +1 per instret pulse in RUN only, saturating, frozen in terminal states.
REQ-019 Without TEST_MONITOR_INSTRET_EN: port and counter absent; instret input unused; all else identical.

Structure
REQ-020 Shared package test_monitor_pkg: state encoding constants (HOLD, RUN, PASS, FAIL, TIMEOUT) and TOHOST_PASS=1 constant.
REQ-021 One sub-module sat_counter (CNT_W, clear, enable, saturating), instantiated for cycle_count and, when enabled, instret_count.

Verification
REQ-022 rst 1 cycle, RESET_CYCLES=2 -> core_rst high exactly 2 cycles after rst low, then 0; cycle_count counts 0,1,2...
REQ-023 In RUN, store 32'h1 to 32'h1000 -> next cycle pass=1, done=1, core_rst=1; cycle_count frozen.
REQ-024 Store 32'h0000_0007 to 32'h1000 -> fail=1, fail_id=3; store 32'h2 to 32'h1000 first -> ignored, stays RUN.
REQ-025 TIMEOUT_CYCLES=10, no store -> timeout=1 after 10 RUN cycles; store 32'h1 on cycle 9 -> pass=1, timeout=0.
REQ-026 Store 32'h1 to 32'h1004, or store during HOLD -> no status change.
REQ-027 rst asserted in PASS -> all status 0, HOLD re-entered; with TEST_MONITOR_INSTRET_EN, 5 instret pulses in RUN -> instret_count=5, pulses during HOLD not counted.
